multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have port opcode, input, 6 bits: instruction-register opcode field, sampled in DECODE.
REQ-004 SHALL have port funct, input, 6 bits: instruction-register funct field; used only for opcode 000000 and 000001.
REQ-005 SHALL have port cond_true, input, 1 bit: ALU branch-condition result, valid in BRANCH.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-007 SHALL have port mem_read / mem_write, output, 1 bit each: memory request, held until mem_ready.
REQ-008 SHALL have port ir_write, pc_write, reg_write, output, 1 bit each: register-update enables.
REQ-009 SHALL have port alu_src_a, output, 1 bit (0=PC, 1=rs); alu_src_b, output, 2 bits (00=rt, 01=const 4, 10=sign-ext imm).
REQ-010 SHALL have port alu_force_add, output, 1 bit: overrides ALU_Control selection with 100001 (addu).
REQ-011 SHALL have port reg_dst, output, 1 bit (1=rd, 0=rt); mem_to_reg, output, 1 bit (1=load data).
REQ-012 SHALL have port pc_src, output, 1 bit (0=ALU result, 1=branch target register).
REQ-013 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-014 SHALL have port trap, output, 1 bit: illegal opcode seen.
REQ-015 SHALL have port retired, output, 16 bits: count of completed instructions.

Function
REQ-016 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WB=4, BRANCH=5, TRAP=7; all outputs combinational from state, opcode and handshake inputs (Moore, except the mem_ready-qualified enables).
REQ-017 FETCH SHALL assert mem_read, alu_src_a=0, alu_src_b=01, alu_force_add=1; stay while mem_ready=0; when mem_ready=1, assert ir_write and pc_write (pc_src=0) in that cycle and go to DECODE.
REQ-018 DECODE SHALL last exactly one cycle, drive alu_src_a=0, alu_src_b=10, alu_force_add=1 (branch target precompute), and branch on opcode.
REQ-019 DECODE transitions SHALL be: 000000, 001000-001110, 001111 -> EXEC; 100000, 100011, 101000, 101011 -> EXEC; 000001, 000100-000111 -> BRANCH; any other -> TRAP.
REQ-020 EXEC SHALL drive alu_src_a=1; alu_src_b=00 for R-type, else 10; alu_force_add=0 except loads/stores (=1); then loads/stores -> MEMACC, others -> WB.
REQ-021 MEMACC SHALL assert mem_read (loads) or mem_write (stores) until mem_ready; on mem_ready a store completes (-> FETCH), a load -> WB.
REQ-022 WB SHALL assert reg_write for one cycle, reg_dst=1 only for R-type, mem_to_reg=1 only for loads, then -> FETCH.
REQ-023 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_force_add=0; assert pc_write with pc_src=1 iff cond_true=1; -> FETCH in one cycle.
REQ-024 TRAP SHALL assert trap=1, hold all enables and memory requests at 0, and remain until reset.
REQ-025 Latency with mem_ready tied high: R/I-type 4 cycles, load 5, store 4, branch 3; each mem_ready=0 cycle adds one.
REQ-026 retired SHALL increment by 1 on the last cycle of each instruction (WB exit, store MEMACC exit, BRANCH exit); wraps FFFF -> 0000; TRAP does not increment.
REQ-027 mem_ready SHALL be ignored in DECODE, EXEC, WB, BRANCH, TRAP.
REQ-028 Opcode and funct changes while not in DECODE/EXEC/WB SHALL not affect state transitions.

Reset
REQ-029 reset=1 at a clock edge SHALL force state=FETCH, trap=0, retired=0, from any state including mid memory wait; reset has priority over all transitions.
REQ-030 While reset=1, all enables and memory requests SHALL be 0.

Verification
REQ-031 addi (001000), mem_ready=1: states 0,1,2,4,0; reg_write=1 only in cycle 4, reg_dst=0; retired 0->1.
REQ-032 lw (100011), mem_ready low 2 cycles in MEMACC: mem_read held 3 cycles, total 7 cycles, mem_to_reg=1 in WB.
REQ-033 beq with cond_true=1 then cond_true=0: pc_write/pc_src=1 in BRANCH only for first; both 3 cycles; retired +2.
REQ-034 opcode 111111 in DECODE: state=7, trap=1, no enables for 10 cycles; reset -> state 0, trap 0.
REQ-035 reset asserted during FETCH wait: next state FETCH, retired=0, no ir_write.
REQ-036 retired preloaded by 65535 instructions, one more sw: retired wraps to 0000.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle FSM sequencing fetch/decode/exec/memory/writeback with retirement counter
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        cond_true,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        alu_force_add,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic [2:0]  state,
  output logic        trap,
  output logic [15:0] retired
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEMACC = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] BRANCH = 3'd5;
  localparam logic [2:0] TRAP   = 3'd7;
  logic [2:0] nxt;
  logic [5:0] op_q, op;
  logic       ld, st, ldst, rtype, alu_ok, br_ok, done;
  logic       unused_funct;
  assign unused_funct = ^funct;
  // opcode is captured in DECODE so later states ignore changes on the bus
  assign op     = (state == DECODE) ? opcode : op_q;
  assign ld     = (op == 6'b100000) || (op == 6'b100011);
  assign st     = (op == 6'b101000) || (op == 6'b101011);
  assign ldst   = ld || st;
  assign rtype  = (op == 6'b000000);
  assign alu_ok = rtype || (op[5:3] == 3'b001) || ldst;
  assign br_ok  = (op == 6'b000001) || (op[5:2] == 4'b0001);
  assign done   = (state == WB) || (state == BRANCH) || (state == MEMACC && st && mem_ready);
  always_comb begin
    nxt = state;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_force_add = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    pc_src = 1'b0;
    trap = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        alu_force_add = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        alu_force_add = 1'b1;
        nxt = alu_ok ? EXEC : br_ok ? BRANCH : TRAP;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = rtype ? 2'b00 : 2'b10;
        alu_force_add = ldst;
        nxt = ldst ? MEMACC : WB;
      end
      MEMACC: begin
        mem_read = ld;
        mem_write = st;
        nxt = mem_ready ? (st ? FETCH : WB) : MEMACC;
      end
      WB: begin
        reg_write = 1'b1;
        reg_dst = rtype;
        mem_to_reg = ld;
        nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        pc_write = cond_true;
        pc_src = cond_true;
        nxt = FETCH;
      end
      TRAP: trap = 1'b1;
      default: nxt = FETCH;
    endcase
    if (reset) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      reg_write = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      retired <= 16'd0;
      op_q <= 6'd0;
    end else begin
      state <= nxt;
      if (done) retired <= retired + 16'd1;
      if (state == DECODE) op_q <= opcode;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors checked by a queue-based monitor
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1, cond_true = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic mem_read, mem_write, ir_write, pc_write, reg_write, alu_src_a, alu_force_add;
  logic reg_dst, mem_to_reg, pc_src, trap;
  logic [1:0] alu_src_b;
  logic [2:0] state;
  logic [15:0] retired;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    string nm;
    logic [2:0] st;
    logic [12:0] ctl;
    logic [15:0] ret;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [12:0] act;
  // ctl = {mem_read, mem_write, ir_write, pc_write, reg_write, alu_src_a, alu_src_b, alu_force_add, reg_dst, mem_to_reg, pc_src, trap}
  localparam logic [12:0] F_W   = 13'b1_0_0_0_0_0_01_1_0_0_0_0;
  localparam logic [12:0] F_G   = 13'b1_0_1_1_0_0_01_1_0_0_0_0;
  localparam logic [12:0] RST_F = 13'b0_0_0_0_0_0_01_1_0_0_0_0;
  localparam logic [12:0] DEC   = 13'b0_0_0_0_0_0_10_1_0_0_0_0;
  localparam logic [12:0] EX_R  = 13'b0_0_0_0_0_1_00_0_0_0_0_0;
  localparam logic [12:0] EX_I  = 13'b0_0_0_0_0_1_10_0_0_0_0_0;
  localparam logic [12:0] EX_M  = 13'b0_0_0_0_0_1_10_1_0_0_0_0;
  localparam logic [12:0] M_LD  = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] M_ST  = 13'b0_1_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] WB_I  = 13'b0_0_0_0_1_0_00_0_0_0_0_0;
  localparam logic [12:0] WB_R  = 13'b0_0_0_0_1_0_00_0_1_0_0_0;
  localparam logic [12:0] WB_L  = 13'b0_0_0_0_1_0_00_0_0_1_0_0;
  localparam logic [12:0] BR_T  = 13'b0_0_0_1_0_1_00_0_0_0_1_0;
  localparam logic [12:0] BR_N  = 13'b0_0_0_0_0_1_00_0_0_0_0_0;
  localparam logic [12:0] TRP   = 13'b0_0_0_0_0_0_00_0_0_0_0_1;
  localparam logic [5:0] G = 6'b111111, A = 6'b001000, L = 6'b100011;
  localparam logic [5:0] R = 6'b000000, S = 6'b101011, B = 6'b000100;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .cond_true(cond_true),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_force_add(alu_force_add), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
    .state(state), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  assign act = {mem_read, mem_write, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
                alu_force_add, reg_dst, mem_to_reg, pc_src, trap};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests += 3;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %0d exp %0d", e.nm, state, e.st);
      end
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b exp %b", e.nm, act, e.ctl);
      end
      if (retired !== e.ret) begin
        n_fail++;
        $display("FAIL %s retired got %h exp %h", e.nm, retired, e.ret);
      end
    end
  end

  task automatic step(input string nm, input logic [5:0] op, input logic c, input logic m,
                      input logic r, input logic [2:0] s, input logic [12:0] k, input logic [15:0] rt);
    @(posedge clk);
    #1;
    opcode = op;
    cond_true = c;
    mem_ready = m;
    reset = r;
    funct = 6'($urandom);
    q.push_back('{nm, s, k, rt});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step("addi_f", G, 0, 1, 0, 3'd0, F_G, 16'd0);
    step("addi_d", A, 0, 0, 0, 3'd1, DEC, 16'd0);
    step("addi_e", A, 0, 0, 0, 3'd2, EX_I, 16'd0);
    step("addi_w", A, 0, 0, 0, 3'd4, WB_I, 16'd0);
    step("lw_f", G, 0, 1, 0, 3'd0, F_G, 16'd1);
    step("lw_d", L, 0, 0, 0, 3'd1, DEC, 16'd1);
    step("lw_e", L, 0, 0, 0, 3'd2, EX_M, 16'd1);
    step("lw_m0", G, 0, 0, 0, 3'd3, M_LD, 16'd1);
    step("lw_m1", G, 0, 0, 0, 3'd3, M_LD, 16'd1);
    step("lw_m2", G, 0, 1, 0, 3'd3, M_LD, 16'd1);
    step("lw_w", L, 0, 0, 0, 3'd4, WB_L, 16'd1);
    step("r_f", G, 0, 1, 0, 3'd0, F_G, 16'd2);
    step("r_d", R, 0, 0, 0, 3'd1, DEC, 16'd2);
    step("r_e", R, 0, 0, 0, 3'd2, EX_R, 16'd2);
    step("r_w", R, 0, 0, 0, 3'd4, WB_R, 16'd2);
    step("sw_fw", G, 0, 0, 0, 3'd0, F_W, 16'd3);
    step("sw_f", G, 0, 1, 0, 3'd0, F_G, 16'd3);
    step("sw_d", S, 0, 0, 0, 3'd1, DEC, 16'd3);
    step("sw_e", S, 0, 0, 0, 3'd2, EX_M, 16'd3);
    step("sw_m", G, 0, 1, 0, 3'd3, M_ST, 16'd3);
    step("bt_f", G, 0, 1, 0, 3'd0, F_G, 16'd4);
    step("bt_d", B, 0, 0, 0, 3'd1, DEC, 16'd4);
    step("bt_b", G, 1, 0, 0, 3'd5, BR_T, 16'd4);
    step("bn_f", G, 0, 1, 0, 3'd0, F_G, 16'd5);
    step("bn_d", B, 0, 0, 0, 3'd1, DEC, 16'd5);
    step("bn_b", G, 0, 1, 0, 3'd5, BR_N, 16'd5);
    step("rs_fw", G, 0, 0, 0, 3'd0, F_W, 16'd6);
    step("rs_a", G, 0, 1, 1, 3'd0, RST_F, 16'd6);
    step("rs_fw2", G, 0, 0, 0, 3'd0, F_W, 16'd0);
    step("tr_f", G, 0, 1, 0, 3'd0, F_G, 16'd0);
    step("tr_d", G, 0, 1, 0, 3'd1, DEC, 16'd0);
    for (int i = 0; i < 10; i++) step("tr_h", G, 1, 1, 0, 3'd7, TRP, 16'd0);
    step("tr_r", G, 0, 0, 1, 3'd7, TRP, 16'd0);
    step("tr_fw", G, 0, 0, 0, 3'd0, F_W, 16'd0);
    @(negedge clk);
    #1 force dut.retired = 16'hffff;
    #1 release dut.retired;
    step("wr_f", G, 0, 1, 0, 3'd0, F_G, 16'hffff);
    step("wr_d", S, 0, 0, 0, 3'd1, DEC, 16'hffff);
    step("wr_e", S, 0, 0, 0, 3'd2, EX_M, 16'hffff);
    step("wr_m", G, 0, 1, 0, 3'd3, M_ST, 16'hffff);
    step("wr_z", G, 0, 0, 0, 3'd0, F_W, 16'h0000);
    repeat (4) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
